// File: rtl/rx_arbiter_rr_if.sv
// Push-side handshake and FIFO write bundle for rx_arbiter_rr.
// slave: the arbiter; master: the senders plus the FIFO status source.
interface rx_arbiter_rr_if #(
    parameter int PORTS = 5,
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(PORTS)
);
    logic [PORTS-1:0]       push_req;
    logic [PORTS-1:0]       push_ack;
    logic [WIDTH*PORTS-1:0] push_data;
    logic                   fifo_full;
    logic                   fifo_write;
    logic [WIDTH-1:0]       fifo_item_in;
    logic [PW-1:0]          fifo_port;

    modport slave (
        input  push_req, push_data, fifo_full,
        output push_ack, fifo_write, fifo_item_in, fifo_port
    );

    modport master (
        output push_req, push_data, fifo_full,
        input  push_ack, fifo_write, fifo_item_in, fifo_port
    );
endinterface

// File: rtl/rx_arbiter_rr.sv
// Receive-side arbiter: collects items from PORTS two-phase req/ack senders,
// grants at most one pending sender per cycle (fixed priority or round-robin)
// and writes the granted item into the router input FIFO.
// Module parameters must match those of the connected interface instance.
module rx_arbiter_rr #(
    parameter int ID       = -1,
    parameter int PORTS    = 5,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = 1,
    parameter int PW       = $clog2(PORTS)
) (
    input  logic            clk,
    input  logic            reset,
    rx_arbiter_rr_if.slave  bus
);

    if (PORTS < 2 || PORTS > 16 || WIDTH < 1 || (ARB_MODE != 0 && ARB_MODE != 1)) begin : g_bad_params
        $error("rx_arbiter_rr %0d: unsupported parameter set", ID);
    end

    logic [PORTS-1:0] r_ack;
    logic             r_write;
    logic [WIDTH-1:0] r_item;
    logic [PW-1:0]    r_port;
    logic [PW-1:0]    r_rr_ptr;

    logic [PORTS-1:0] w_pend;
    logic             w_grant_vld;
    logic [PW-1:0]    w_grant;
    logic [PW-1:0]    w_next_ptr;
    logic [WIDTH-1:0] w_item;
    logic             w_do_grant;

    // A sender is pending whenever its req and ack phases differ.
    assign w_pend     = bus.push_req ^ r_ack;
    assign w_do_grant = w_grant_vld && !bus.fifo_full;
    assign w_item     = bus.push_data[w_grant*WIDTH +: WIDTH];
    assign w_next_ptr = (w_grant == PW'(PORTS - 1)) ? '0 : w_grant + PW'(1);

    // Pick the winning pending port for this cycle.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        if (ARB_MODE == 0) begin
            // Ascending scan; later hits overwrite, so the highest index wins.
            for (int unsigned k = 0; k < PORTS; k++) begin
                if (w_pend[k]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = PW'(k);
                end
            end
        end else begin
            // Scan upward from the pointer with wrap; first pending port wins.
            for (int unsigned i = 0; i < PORTS; i++) begin
                logic [PW:0]   sum;
                logic [PW-1:0] idx;
                sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
                if (sum >= (PW+1)'(PORTS)) begin
                    sum = sum - (PW+1)'(PORTS);
                end
                idx = sum[PW-1:0];
                if (!w_grant_vld && w_pend[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = idx;
                end
            end
        end
    end

    // Register the grant: toggle the ack, strobe the FIFO, advance the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack    <= '0;
            r_write  <= 1'b0;
            r_item   <= '0;
            r_port   <= '0;
            r_rr_ptr <= '0;
        end else if (w_do_grant) begin
            r_ack[w_grant] <= ~r_ack[w_grant];
            r_write        <= 1'b1;
            r_item         <= w_item;
            r_port         <= w_grant;
            if (ARB_MODE != 0) begin
                r_rr_ptr <= w_next_ptr;
            end
        end else begin
            r_write <= 1'b0;
        end
    end

    assign bus.push_ack     = r_ack;
    assign bus.fifo_write   = r_write;
    assign bus.fifo_item_in = r_item;
    assign bus.fifo_port    = r_port;

endmodule

// File: tb/tb_rx_arbiter_rr.sv
// Directed bench for rx_arbiter_rr: three instances cover round-robin and
// fixed priority at PORTS=5, and round-robin wrap at PORTS=3, WIDTH=16.
module tb_rx_arbiter_rr;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rx_arbiter_rr_if #(.PORTS(5), .WIDTH(8))  ifa ();
    rx_arbiter_rr_if #(.PORTS(5), .WIDTH(8))  ifb ();
    rx_arbiter_rr_if #(.PORTS(3), .WIDTH(16)) ifc ();

    rx_arbiter_rr #(.ID(1), .PORTS(5), .WIDTH(8), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .bus(ifa));
    rx_arbiter_rr #(.ID(2), .PORTS(5), .WIDTH(8), .ARB_MODE(0)) u_fp (
        .clk(clk), .reset(reset), .bus(ifb));
    rx_arbiter_rr #(.ID(3), .PORTS(3), .WIDTH(16), .ARB_MODE(1)) u_rr3 (
        .clk(clk), .reset(reset), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned a_ord [3];
        int unsigned b_ord [3];
        logic [15:0] cdata [3];
        int          cnt   [3];
        int unsigned g;

        n_checks = 0;
        n_fail   = 0;
        a_ord = '{0, 1, 4};
        b_ord = '{4, 1, 0};
        cnt   = '{0, 0, 0};

        reset = 1'b1;
        ifa.push_req = '0; ifa.push_data = '0; ifa.fifo_full = 1'b0;
        ifb.push_req = '0; ifb.push_data = '0; ifb.fifo_full = 1'b0;
        ifc.push_req = '0; ifc.push_data = '0; ifc.fifo_full = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ack_a",   32'(ifa.push_ack),     32'h0);
        check("rst_wr_a",    32'(ifa.fifo_write),   32'h0);
        check("rst_item_a",  32'(ifa.fifo_item_in), 32'h0);
        check("rst_port_a",  32'(ifa.fifo_port),    32'h0);
        check("rst_ack_b",   32'(ifb.push_ack),     32'h0);
        check("rst_ack_c",   32'(ifc.push_ack),     32'h0);
        reset = 1'b0;

        // Single item on port 2
        ifa.push_data[2*8 +: 8] = 8'hA5;
        ifa.push_req[2] = 1'b1;
        tick();
        check("single_wr",   32'(ifa.fifo_write),   32'h1);
        check("single_item", 32'(ifa.fifo_item_in), 32'hA5);
        check("single_port", 32'(ifa.fifo_port),    32'h2);
        check("single_ack",  32'(ifa.push_ack),     32'h04);
        tick();
        check("single_wr_off",  32'(ifa.fifo_write),   32'h0);
        check("single_item_hd", 32'(ifa.fifo_item_in), 32'hA5);
        check("single_port_hd", 32'(ifa.fifo_port),    32'h2);
        check("single_ack_hd",  32'(ifa.push_ack),     32'h04);

        // Fresh start so the round-robin pointer is back at 0
        reset = 1'b1;
        ifa.push_req = '0;
        tick();
        reset = 1'b0;

        // Ports 0, 1, 4 toggle together on both PORTS=5 instances
        ifa.push_data[0*8 +: 8] = 8'h10; ifb.push_data[0*8 +: 8] = 8'h10;
        ifa.push_data[1*8 +: 8] = 8'h11; ifb.push_data[1*8 +: 8] = 8'h11;
        ifa.push_data[4*8 +: 8] = 8'h14; ifb.push_data[4*8 +: 8] = 8'h14;
        ifa.push_req = 5'b10011;
        ifb.push_req = 5'b10011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr_wr",   32'(ifa.fifo_write),   32'h1);
            check("rr_port", 32'(ifa.fifo_port),    a_ord[i]);
            check("rr_item", 32'(ifa.fifo_item_in), 32'h10 + a_ord[i]);
            check("fp_wr",   32'(ifb.fifo_write),   32'h1);
            check("fp_port", 32'(ifb.fifo_port),    b_ord[i]);
            check("fp_item", 32'(ifb.fifo_item_in), 32'h10 + b_ord[i]);
        end
        tick();
        check("rr_done_wr",  32'(ifa.fifo_write), 32'h0);
        check("rr_done_ack", 32'(ifa.push_ack),   32'h13);
        check("fp_done_wr",  32'(ifb.fifo_write), 32'h0);
        check("fp_done_ack", 32'(ifb.push_ack),   32'h13);

        // Backpressure: port 3 waits out 5 full cycles
        ifa.fifo_full = 1'b1;
        ifa.push_data[3*8 +: 8] = 8'h33;
        ifa.push_req[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_wr",  32'(ifa.fifo_write), 32'h0);
            check("bp_ack", 32'(ifa.push_ack),   32'h13);
        end
        ifa.fifo_full = 1'b0;
        tick();
        check("bp_rel_wr",   32'(ifa.fifo_write),   32'h1);
        check("bp_rel_port", 32'(ifa.fifo_port),    32'h3);
        check("bp_rel_item", 32'(ifa.fifo_item_in), 32'h33);
        check("bp_rel_ack",  32'(ifa.push_ack),     32'h1B);

        // Fairness and pointer wrap at PORTS=3
        for (int k = 0; k < 3; k++) begin
            cdata[k] = 16'hC000 + 16'(k);
            ifc.push_data[k*16 +: 16] = cdata[k];
        end
        ifc.push_req = 3'b111;
        for (int i = 0; i < 30; i++) begin
            tick();
            g = 32'(i % 3);
            check("fair_wr",   32'(ifc.fifo_write),   32'h1);
            check("fair_port", 32'(ifc.fifo_port),    g);
            check("fair_item", 32'(ifc.fifo_item_in), 32'(cdata[g]));
            if (ifc.fifo_write === 1'b1 && 32'(ifc.fifo_port) < 3) begin
                cnt[ifc.fifo_port]++;
            end
            cdata[g] = 16'h0100 * 16'(i + 1) + 16'(g);
            ifc.push_data[g*16 +: 16] = cdata[g];
            ifc.push_req[g] = ~ifc.push_req[g];
        end
        for (int k = 0; k < 3; k++) begin
            check("fair_count", 32'(cnt[k]), 32'd10);
        end

        // Reset mid-stream with ports 0 and 1 pending behind a full FIFO
        ifa.fifo_full = 1'b1;
        ifa.push_req[0] = 1'b0;
        ifa.push_req[1] = 1'b0;
        tick();
        check("mid_hold_wr", 32'(ifa.fifo_write), 32'h0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_ack",  32'(ifa.push_ack),     32'h0);
        check("mid_wr",   32'(ifa.fifo_write),   32'h0);
        check("mid_item", 32'(ifa.fifo_item_in), 32'h0);
        check("mid_port", 32'(ifa.fifo_port),    32'h0);
        ifa.push_req  = '0;
        ifc.push_req  = '0;
        ifa.fifo_full = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_wr",  32'(ifa.fifo_write), 32'h0);
            check("post_rst_ack", 32'(ifa.push_ack),   32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
